// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-frame output bundle of the parametrised UART receiver
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;
  logic                 o_Busy;

  modport master (
    output o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
  );

  modport slave (
    input  o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver, 3-sample majority vote per bit
// Reports parity error, framing error and break; one DV pulse per frame.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Rx_Serial,
  uart_rx_param_if.master rx
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_DEC   = CW'((CLKS_PER_BIT - 1) / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, DONE, WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 rx_meta, rx_s;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 smp0, smp1;
  logic                 par_bit, perr, ferr, stop0_low;
  logic                 maj, at_dec, cnt_end;

  // Third vote is the live sample, so the decision lands on count MID+1.
  assign maj     = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
  assign at_dec  = (cnt == CNT_DEC);
  assign cnt_end = (cnt == CNT_LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta          <= 1'b1;
      rx_s             <= 1'b1;
      state            <= IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      shreg            <= '0;
      smp0             <= 1'b1;
      smp1             <= 1'b1;
      par_bit          <= 1'b0;
      perr             <= 1'b0;
      ferr             <= 1'b0;
      stop0_low        <= 1'b0;
      rx.o_Rx_DV       <= 1'b0;
      rx.o_Rx_Byte     <= '0;
      rx.o_Parity_Err  <= 1'b0;
      rx.o_Frame_Err   <= 1'b0;
      rx.o_Break       <= 1'b0;
      rx.o_Busy        <= 1'b0;
    end else begin
      rx_meta    <= i_Rx_Serial;
      rx_s       <= rx_meta;
      rx.o_Rx_DV <= 1'b0;
      if (cnt == CNT_PRE) smp0 <= rx_s;
      if (cnt == CNT_MID) smp1 <= rx_s;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state     <= START;
            bit_idx   <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            stop0_low <= 1'b0;
            rx.o_Busy <= 1'b1;
          end
        end

        START: begin
          if (at_dec && maj) begin
            state     <= IDLE;
            cnt       <= '0;
            rx.o_Busy <= 1'b0;
          end else if (cnt_end) begin
            state <= DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (cnt_end) begin
            cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        PAR: begin
          if (at_dec) begin
            par_bit <= maj;
            perr    <= (^shreg) ^ maj ^ (PARITY == 1);
          end
          if (cnt_end) begin
            cnt   <= '0;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (at_dec) begin
            if (bit_idx == 4'd0) stop0_low <= !maj;
            ferr <= ferr | !maj;
            if (bit_idx == STOP_LAST) begin
              // Leave at the final decision to keep half a bit of margin for the next start.
              state           <= DONE;
              cnt             <= '0;
              rx.o_Rx_DV      <= 1'b1;
              rx.o_Rx_Byte    <= shreg;
              rx.o_Parity_Err <= perr;
              rx.o_Frame_Err  <= ferr | !maj;
              rx.o_Break      <= (shreg == '0) && (PARITY == 0 || !par_bit) &&
                                 ((bit_idx == 4'd0) ? !maj : stop0_low);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (cnt_end) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 4'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          cnt       <= '0;
          state     <= ferr ? WAIT_IDLE : IDLE;
          rx.o_Busy <= ferr;
        end

        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            state     <= IDLE;
            rx.o_Busy <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          rx.o_Busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
